bcd_accumulator: RTL and testbench

- Multi-digit BCD accumulator for the DE2 switch/7-segment lab platform. Successor to the 4-bit single-shot switch adder.
- The digit count is parametrised. The block supports add and subtract (10's complement) modes and holds a registered running total.
- Arithmetic runs digit-serially, least-significant digit first, under a small FSM with start/done handshake and invalid-operand detection.
- It drives one 7-segment display bank for the accumulator and one for the operand.

---
 rtl/bcd_accumulator.sv | 175 +++++++++++++++++
 tb/tb_bcd_accumulator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_accumulator.sv
// Purpose: multi-digit BCD add/subtract accumulator with 7-segment drive for the accumulator and operand banks.
// Latency: done pulses DIGITS+2 cycles after the start cycle (2 for a rejected operand); acc_bcd updates one cycle later.
// Backpressure: none; requests (go edges, clr) arriving while busy are dropped, and busy tells the caller when to retry.
//
// Ports:
//   CLOCK_50, RESET_N  clock and asynchronous active-low reset
//   SW                 operand, digit i at SW[4i+3:4i] (digit 0 least significant)
//   op_sub             0 = add, 1 = subtract, sampled at start
//   go                 level input; a rising edge requests an operation
//   clr                synchronous accumulator clear, honoured in IDLE only
//   acc_bcd, carry     registered total and carry/borrow of the last valid operation
//   err, busy, done    operand-invalid flag, not-idle flag, one-cycle completion pulse
//   HEX_ACC, HEX_OPD   active-low segments (bit 7i+0 = a ... 7i+6 = g) for acc_bcd and SW
module bcd_accumulator #(
    parameter int DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [4*DIGITS-1:0]   SW,
    input  logic                  op_sub,
    input  logic                  go,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   acc_bcd,
    output logic                  carry,
    output logic                  err,
    output logic                  busy,
    output logic                  done,
    output logic [7*DIGITS-1:0]   HEX_ACC,
    output logic [7*DIGITS-1:0]   HEX_OPD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state;
    logic                go_d;
    logic                start;
    logic [4*DIGITS-1:0] opd_r;
    logic [4*DIGITS-1:0] res_r;
    logic                sub_r;
    logic [3:0]          idx;
    logic                c;

    logic                opd_bad;
    logic [3:0]          dig_a;
    logic [3:0]          dig_b;
    logic [4:0]          dig_sum;
    logic [3:0]          dig_out;
    logic                dig_cout;

    assign start = go & ~go_d;

    // Segment lookup table is written a..g left to right for readability,
    // then bit-reversed so that segment a lands on bit 0.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        logic [6:0] r;
        case (d)
            4'd0:    p = 7'b0000001;
            4'd1:    p = 7'b1001111;
            4'd2:    p = 7'b0010010;
            4'd3:    p = 7'b0000110;
            4'd4:    p = 7'b1001100;
            4'd5:    p = 7'b0100100;
            4'd6:    p = 7'b0100000;
            4'd7:    p = 7'b0001111;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0001100;
            default: p = 7'b1111111;
        endcase
        for (int k = 0; k < 7; k++) begin
            r[k] = p[6-k];
        end
        return r;
    endfunction

    always_comb begin
        HEX_ACC = '0;
        HEX_OPD = '0;
        for (int i = 0; i < DIGITS; i++) begin
            HEX_ACC[7*i +: 7] = seg7(acc_bcd[4*i +: 4]);
            HEX_OPD[7*i +: 7] = seg7(SW[4*i +: 4]);
        end
    end

    always_comb begin
        opd_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (opd_r[4*i +: 4] > 4'd9) begin
                opd_bad = 1'b1;
            end
        end
    end

    // One digit per cycle. Subtraction is acc + (nines' complement of opd) + 1,
    // the +1 entering as the initial carry loaded in CHECK.
    always_comb begin
        dig_a    = acc_bcd[4*idx +: 4];
        dig_b    = sub_r ? (4'd9 - opd_r[4*idx +: 4]) : opd_r[4*idx +: 4];
        dig_sum  = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, c};
        dig_cout = (dig_sum > 5'd9);
        dig_out  = dig_cout ? 4'(dig_sum - 5'd10) : dig_sum[3:0];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            go_d    <= 1'b1;   // a go level held through reset must not look like an edge
            acc_bcd <= '0;
            carry   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            opd_r   <= '0;
            res_r   <= '0;
            sub_r   <= 1'b0;
            idx     <= '0;
            c       <= 1'b0;
        end else begin
            go_d <= go;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        acc_bcd <= '0;
                        carry   <= 1'b0;
                        err     <= 1'b0;
                    end else if (start) begin
                        opd_r <= SW;
                        sub_r <= op_sub;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (opd_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        err   <= 1'b0;
                        idx   <= '0;
                        c     <= sub_r;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_r[4*idx +: 4] <= dig_out;
                    c                 <= dig_cout;
                    if (idx == 4'(DIGITS - 1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                FIN: begin
                    // err still reflects this operation's CHECK result here.
                    if (!err) begin
                        acc_bcd <= res_r;
                        carry   <= sub_r ? ~c : c;
                    end
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_accumulator.sv
module tb_bcd_accumulator;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sw;
    logic        op_sub;
    logic        go;
    logic        clr;
    logic [7:0]  acc_bcd;
    logic        carry;
    logic        err;
    logic        busy;
    logic        done;
    logic [13:0] hex_acc;
    logic [13:0] hex_opd;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int n_done;

    bcd_accumulator #(.DIGITS(2)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .SW       (sw),
        .op_sub   (op_sub),
        .go       (go),
        .clr      (clr),
        .acc_bcd  (acc_bcd),
        .carry    (carry),
        .err      (err),
        .busy     (busy),
        .done     (done),
        .HEX_ACC  (hex_acc),
        .HEX_OPD  (hex_opd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise go, wait (bounded) for done, scramble SW/op_sub after the start
    // edge, then step one more cycle so the accumulator update is visible.
    task automatic do_op(input logic [7:0] opd, input logic sub, output int latency);
        sw     = opd;
        op_sub = sub;
        go     = 1'b1;
        latency = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                sw     = ~opd;
                op_sub = ~sub;
            end
            if (done) begin
                latency = k;
                break;
            end
        end
        go = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_op(input string tag, input int exp_lat, input logic [7:0] exp_acc,
                            input logic exp_carry, input logic exp_err);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_acc"}, acc_bcd, exp_acc);
        chk({tag, "_carry"}, carry, exp_carry);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        chk({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        // Reset, with go held high across release.
        rst_n  = 1'b0;
        go     = 1'b1;
        clr    = 1'b0;
        op_sub = 1'b0;
        sw     = 8'h11;
        repeat (3) @(negedge clk);
        chk("reset_acc", acc_bcd, 8'h00);
        chk("reset_hex_acc", hex_acc, {7'h40, 7'h40});
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_carry", carry, 1'b0);
        chk("reset_err", err, 1'b0);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("go_held_through_reset_activity", n_done, 0);
        chk("go_held_through_reset_acc", acc_bcd, 8'h00);
        go = 1'b0;
        @(negedge clk);

        // Adds.
        do_op(8'h47, 1'b0, lat);
        check_op("add47", 4, 8'h47, 1'b0, 1'b0);
        do_op(8'h38, 1'b0, lat);
        check_op("add38", 4, 8'h85, 1'b0, 1'b0);
        do_op(8'h85, 1'b0, lat);
        check_op("add85_overflow", 4, 8'h70, 1'b1, 1'b0);

        // Subtracts.
        do_op(8'h25, 1'b1, lat);
        check_op("sub25", 4, 8'h45, 1'b0, 1'b0);
        do_op(8'h50, 1'b1, lat);
        check_op("sub50_borrow", 4, 8'h95, 1'b1, 1'b0);
        do_op(8'h00, 1'b1, lat);
        check_op("sub00", 4, 8'h95, 1'b0, 1'b0);

        // Invalid operand: digit0 blank, digit1 shows 3.
        sw = 8'h3A;
        @(negedge clk);
        chk("hex_opd_3A", hex_opd, {7'h30, 7'h7F});
        do_op(8'h3A, 1'b0, lat);
        check_op("invalid_3A", 2, 8'h95, 1'b0, 1'b1);
        do_op(8'h01, 1'b0, lat);
        check_op("add01_clears_err", 4, 8'h96, 1'b0, 1'b0);
        chk("hex_acc_96", hex_acc, {7'h18, 7'h02});

        // go toggled while busy: only one operation may run.
        sw     = 8'h01;
        op_sub = 1'b0;
        go     = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) go = 1'b0;
            if (k == 2) go = 1'b1;
            if (k == 3) go = 1'b0;
            if (done) n_done++;
        end
        chk("busy_toggle_done_count", n_done, 1);
        chk("busy_toggle_acc", acc_bcd, 8'h97);
        chk("busy_toggle_idle", busy, 1'b0);

        // clr and go rising together: clear wins, nothing starts.
        sw  = 8'h05;
        clr = 1'b1;
        go  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_go_acc", acc_bcd, 8'h00);
        chk("clr_go_busy", busy, 1'b0);
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("clr_go_no_op", n_done, 0);
        go = 1'b0;
        @(negedge clk);

        // Reset during RUN.
        do_op(8'h12, 1'b0, lat);
        check_op("add12", 4, 8'h12, 1'b0, 1'b0);
        sw = 8'h11;
        go = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("midrun_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_acc", acc_bcd, 8'h00);
        chk("midrun_reset_busy", busy, 1'b0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("after_reset_acc", acc_bcd, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
